serial_word_receiver6: RTL and testbench
========================================

Name: serial_word_receiver6

Overview:
Downstream consumer of the 6-bit right-shift register. It samples that register's serial output (signal_q[0]) LSB-first after a preset load and reassembles the 6-bit word. It then flags completion with a one-cycle valid pulse and compares the word against a fixed pattern. It also counts completed frames, so the lab board can verify shift-register operation end to end.

Parameters:
WIDTH, 6, number of bits per frame; also the width of signal_word.
MATCH_PATTERN, 6'b110000, word value that asserts signal_match.
CNT_W, 8, width of the completed-frame counter.

Ports:
clockpulse  input  1  system clock; all state updates on the rising edge.
clear  input  1  synchronous, active-high reset.
frame_start  input  1  one-cycle strobe, driven in the same cycle as the upstream preset_enable.
serial_input  input  1  upstream signal_q[0], LSB first.
signal_word  output  WIDTH  last completed word; held until the next completion.
signal_valid  output  1  one-cycle pulse when signal_word updates.
signal_match  output  1  (signal_word == MATCH_PATTERN); updated together with signal_word.
signal_busy  output  1  high while in SHIFT.
signal_count  output  3  number of bits sampled in the current frame.
signal_frames  output  CNT_W  completed-frame counter; wraps.

Behaviour:
- Reset (clear=1 at an edge): state=IDLE, internal shift reg=0, bit count=0, signal_word=0, signal_valid=0, signal_match=0, signal_busy=0, signal_frames=0.
- clear has priority over every other input; clear mid-frame discards the partial word and produces no valid pulse.
- States:
  - IDLE: frame_start=1 -> SHIFT, count=0. serial_input is ignored in IDLE.
  - SHIFT: each edge, shreg <= {serial_input, shreg[WIDTH-1:1]} and count++.
    - The edge that takes the WIDTH-th sample (count==WIDTH-1) -> DONE.
    - That same edge loads signal_word with the assembled value, signal_valid<=1, signal_match<=compare, signal_frames++.
  - DONE: one cycle with signal_valid=1.
    - Next edge -> IDLE and signal_valid<=0.
    - If frame_start=1 in DONE -> SHIFT with count=0 (back-to-back frames; no sample is taken on that edge).
- frame_start=1 while in SHIFT restarts the frame: count=0, partial data discarded, no valid pulse, signal_frames unchanged. The restart edge takes no sample.
- Timing:
  - frame_start sampled at edge E0.
  - Samples are taken at E1..E6, capturing upstream preset[0]..preset[5].
  - signal_valid is high for the cycle after E6, i.e. latency is 6 clocks from the frame_start edge.
- signal_busy = (state==SHIFT), combinational from state.
- signal_count = count register, reset to 0 on IDLE entry.
- signal_frames wraps 2^CNT_W-1 -> 0 with no saturation and no flag.
- Widths: count is 3 bits and must hold 0..WIDTH-1. Only WIDTH<=8 is supported.
- No X propagation: state encoding is full-case, and unused encodings return to IDLE.

Decomposition:
- Shared header (receiver_defs.vh): state encodings ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2, plus the default MATCH_PATTERN.
- Natural sub-module: frame_counter (CNT_W-bit wrapping counter with synchronous clear and enable), reusable by later lab blocks.
- The FSM, shift register and comparator stay in serial_word_receiver6.

Test Plan:
1. Reset, then frame_start with stream 0,0,0,0,1,1 at E1..E6 -> valid pulse after E6; signal_word=6'b110000, signal_match=1, signal_frames=1.
2. Stream for 6'b101010 (0,1,0,1,0,1) -> signal_word=6'b101010, signal_match=0; the word holds with signal_valid=0 for the following 10 idle cycles.
3. frame_start at E3 mid-frame, then a clean 6-bit stream of 110000 -> exactly one valid pulse, 6 cycles after the second strobe; signal_frames increments by 1 only.
4. Back-to-back: frame_start asserted during DONE, two frames 110000 then 000011 -> two valid pulses 7 cycles apart; words 6'b110000 then 6'b000011.
5. clear asserted at E4 of a frame -> all outputs 0 next cycle, no valid pulse; a following frame decodes correctly.
6. Run 256 frames -> signal_frames goes 255 -> 0 on the 256th completion.

Source files
------------

// File: rtl/serial_word_receiver6_pkg.sv
// Shared definitions for the serial word receiver.
// Holds the FSM state encodings and the default match pattern, so that
// later lab blocks built around the same receiver agree on both.
package serial_word_receiver6_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } rx_state_e;

    localparam logic [5:0] MATCH_PATTERN_DEF = 6'b110000;

endpackage

// File: rtl/serial_word_receiver6_frame_counter.sv
// frame_counter: CNT_W-bit wrapping event counter.
// Ports:
//   clk_i   - clock, rising edge
//   clr_i   - synchronous active-high clear (has priority over en_i)
//   en_i    - increment enable
//   count_o - current count; wraps from all-ones to zero with no flag
module frame_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/serial_word_receiver6.sv
// serial_word_receiver6: reassembles a WIDTH-bit word sent LSB-first on
// serial_input after a frame_start strobe, pulses signal_valid for one
// cycle on completion, compares the word with MATCH_PATTERN and counts
// completed frames.
// Ports:
//   clockpulse    - clock, rising edge
//   clear         - synchronous active-high reset, highest priority
//   frame_start   - one-cycle strobe starting (or restarting) a frame
//   serial_input  - serial data, LSB first, sampled on the WIDTH edges after the strobe
//   signal_word   - last completed word, held until the next completion
//   signal_valid  - one-cycle pulse when signal_word updates
//   signal_match  - signal_word == MATCH_PATTERN, updated with signal_word
//   signal_busy   - high while shifting
//   signal_count  - number of bits sampled in the current frame
//   signal_frames - completed-frame counter, wraps
module serial_word_receiver6
    import serial_word_receiver6_pkg::*;
#(
    parameter int               WIDTH         = 6,
    parameter logic [WIDTH-1:0] MATCH_PATTERN = MATCH_PATTERN_DEF,
    parameter int               CNT_W         = 8
) (
    input  logic             clockpulse,
    input  logic             clear,
    input  logic             frame_start,
    input  logic             serial_input,
    output logic [WIDTH-1:0] signal_word,
    output logic             signal_valid,
    output logic             signal_match,
    output logic             signal_busy,
    output logic [2:0]       signal_count,
    output logic [CNT_W-1:0] signal_frames
);

    localparam logic [2:0] LAST_BIT = 3'(WIDTH - 1);

    rx_state_e        state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             valid_q, valid_d;
    logic             match_q, match_d;
    logic             frame_done;

    always_ff @(posedge clockpulse) begin
        if (clear) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            match_q <= match_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        word_d     = word_q;
        valid_d    = 1'b0;
        match_d    = match_q;
        frame_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                end
            end
            ST_SHIFT: begin
                if (frame_start) begin
                    // Restart: the strobe edge takes no sample; stale bits
                    // are fully overwritten by the next WIDTH samples.
                    cnt_d = '0;
                end else begin
                    shreg_d = {serial_input, shreg_q[WIDTH-1:1]};
                    if (cnt_q == LAST_BIT) begin
                        state_d    = ST_DONE;
                        cnt_d      = '0;
                        word_d     = shreg_d;
                        valid_d    = 1'b1;
                        match_d    = (shreg_d == MATCH_PATTERN);
                        frame_done = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            ST_DONE: begin
                state_d = frame_start ? ST_SHIFT : ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    frame_counter #(
        .CNT_W (CNT_W)
    ) u_frame_counter (
        .clk_i   (clockpulse),
        .clr_i   (clear),
        .en_i    (frame_done),
        .count_o (signal_frames)
    );

    assign signal_word  = word_q;
    assign signal_valid = valid_q;
    assign signal_match = match_q;
    assign signal_busy  = (state_q == ST_SHIFT);
    assign signal_count = cnt_q;

endmodule

// File: tb/tb_serial_word_receiver6.sv
module tb_serial_word_receiver6;

    logic       clockpulse = 1'b0;
    logic       clear = 1'b1;
    logic       frame_start = 1'b0;
    logic       serial_input = 1'b0;
    logic [5:0] signal_word;
    logic       signal_valid;
    logic       signal_match;
    logic       signal_busy;
    logic [2:0] signal_count;
    logic [7:0] signal_frames;

    serial_word_receiver6 dut (
        .clockpulse    (clockpulse),
        .clear         (clear),
        .frame_start   (frame_start),
        .serial_input  (serial_input),
        .signal_word   (signal_word),
        .signal_valid  (signal_valid),
        .signal_match  (signal_match),
        .signal_busy   (signal_busy),
        .signal_count  (signal_count),
        .signal_frames (signal_frames)
    );

    always #5 clockpulse = ~clockpulse;

    typedef struct {
        logic [5:0] w;
        logic       m;
        logic [7:0] f;
    } exp_t;

    exp_t       sb[$];
    int         tests = 0;
    int         fails = 0;
    int         pulses = 0;
    logic [7:0] frames_model = 8'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clockpulse);
        #1;
    endtask

    // Expected result is queued when the frame is driven.
    task automatic push_exp(input logic [5:0] w);
        exp_t e;
        frames_model = frames_model + 8'd1;
        e.w = w;
        e.m = (w == 6'b110000);
        e.f = frames_model;
        sb.push_back(e);
    endtask

    // Strobe at E0, samples at E1..E6; returns #1 after E6 where valid must be high.
    task automatic send_frame(input logic [5:0] w);
        push_exp(w);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            serial_input = w[i];
            tick();
        end
        chk("latency_valid", {31'd0, signal_valid}, 32'd1);
    endtask

    // Scoreboard side: every valid pulse pops and checks one expected result.
    always @(negedge clockpulse) begin
        if (signal_valid) begin
            pulses++;
            chk("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_word", {26'd0, signal_word}, {26'd0, e.w});
                chk("sb_match", {31'd0, signal_match}, {31'd0, e.m});
                chk("sb_frames", {24'd0, signal_frames}, {24'd0, e.f});
            end
        end
    end

    initial begin
        int p0;
        // Reset
        tick();
        tick();
        clear = 1'b0;
        chk("rst_word", {26'd0, signal_word}, 32'd0);
        chk("rst_valid", {31'd0, signal_valid}, 32'd0);
        chk("rst_match", {31'd0, signal_match}, 32'd0);
        chk("rst_busy", {31'd0, signal_busy}, 32'd0);
        chk("rst_count", {29'd0, signal_count}, 32'd0);
        chk("rst_frames", {24'd0, signal_frames}, 32'd0);

        // serial_input ignored in IDLE
        for (int i = 0; i < 3; i++) begin
            serial_input = ~serial_input;
            tick();
        end
        chk("idle_busy", {31'd0, signal_busy}, 32'd0);
        chk("idle_count", {29'd0, signal_count}, 32'd0);

        // Test 1: matching pattern
        send_frame(6'b110000);
        chk("t1_word", {26'd0, signal_word}, 32'h30);
        chk("t1_match", {31'd0, signal_match}, 32'd1);
        chk("t1_frames", {24'd0, signal_frames}, 32'd1);
        tick();
        chk("t1_valid_drop", {31'd0, signal_valid}, 32'd0);

        // Test 2: non-matching word, held over idle cycles
        send_frame(6'b101010);
        chk("t2_match", {31'd0, signal_match}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t2_hold_valid", {31'd0, signal_valid}, 32'd0);
            chk("t2_hold_word", {26'd0, signal_word}, 32'h2a);
        end

        // Test 3: restart mid-frame at E3
        p0 = pulses;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("t3_busy", {31'd0, signal_busy}, 32'd1);
        chk("t3_count0", {29'd0, signal_count}, 32'd0);
        serial_input = 1'b1;
        tick();
        serial_input = 1'b1;
        tick();
        chk("t3_count2", {29'd0, signal_count}, 32'd2);
        send_frame(6'b110000);
        chk("t3_frames", {24'd0, signal_frames}, 32'd3);
        tick();
        chk("t3_one_pulse", pulses - p0, 32'd1);

        // Test 4: back-to-back frames, strobe during DONE
        p0 = pulses;
        send_frame(6'b110000);
        send_frame(6'b000011);
        chk("t4_word2", {26'd0, signal_word}, 32'h03);
        tick();
        chk("t4_two_pulses", pulses - p0, 32'd2);

        // Test 5: clear mid-frame at E4
        p0 = pulses;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            serial_input = 1'b1;
            tick();
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        frames_model = 8'd0;
        chk("t5_word", {26'd0, signal_word}, 32'd0);
        chk("t5_valid", {31'd0, signal_valid}, 32'd0);
        chk("t5_match", {31'd0, signal_match}, 32'd0);
        chk("t5_busy", {31'd0, signal_busy}, 32'd0);
        chk("t5_count", {29'd0, signal_count}, 32'd0);
        chk("t5_frames", {24'd0, signal_frames}, 32'd0);
        for (int i = 0; i < 6; i++) tick();
        chk("t5_no_pulse", pulses - p0, 32'd0);
        send_frame(6'b110000);
        chk("t5_after_frames", {24'd0, signal_frames}, 32'd1);
        tick();

        // Test 6: counter wrap
        while (frames_model != 8'd255) begin
            send_frame(6'($urandom_range(0, 63)));
            tick();
        end
        chk("t6_frames_255", {24'd0, signal_frames}, 32'd255);
        send_frame(6'b110000);
        chk("t6_frames_wrap", {24'd0, signal_frames}, 32'd0);
        tick();
        tick();

        chk("sb_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
